lutram_bist: RTL and testbench
==============================

// Module: lutram_bist
// PURPOSE
//  Upstream stimulus/checker for the LUTRAM stress-test array. Drives its addr/we/wdat and checks rdat.
//  Runs a 4-pass march (write P asc, read P asc, write ~P desc, read ~P desc) over every word.
//  Reports done/pass and a saturating error count to board pins, so capacity builds self-check on silicon.
// PARAMETERS
//  NUM_BLOCKS  30      number of 16x10 LUTRAM blocks in the array under test; DEPTH = NUM_BLOCKS*16
//  DW          10      data width; must match array word width
//  RD_LAT      0       array read latency in cycles (0 = async read), legal 0..2
//  SEED        10'h2A5 pattern seed; P(a) = DW'(a) ^ SEED (a zero-extended/truncated to DW)
//  ECW         16      error counter width
// PORTS
//  clk       in   1        system clock
//  rst       in   1        synchronous reset, active-high
//  start     in   1        single-cycle request to run one march; sampled in IDLE only
//  busy      out  1        high while march in progress
//  done      out  1        one-cycle pulse when march completes
//  pass      out  1        valid after done: 1 = zero mismatches; held until next start
//  err_cnt   out  ECW      mismatch count, saturates at all-ones; held until next start
//  mem_addr  out  AW       array address, AW = $clog2(DEPTH)
//  mem_we    out  1        array write enable
//  mem_wdat  out  DW       array write data
//  mem_rdat  in   DW       array read data, valid RD_LAT cycles after mem_addr
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, pass=0, err_cnt=0, mem_addr=0, mem_we=0, mem_wdat=0; compare pipe cleared.
//  FSM: IDLE -> WR0 -> RD0 -> DRN0 -> WR1 -> RD1 -> DRN1 -> FIN -> IDLE.
//   IDLE: start=1 -> WR0, addr=0, err_cnt/pass cleared. start ignored in all other states.
//   WR0: one write/cycle, addr 0..DEPTH-1 asc, wdat=P(addr), we=1. At DEPTH-1 -> RD0, addr=0.
//   RD0: one read/cycle asc, we=0; expected P(addr) pushed into RD_LAT-deep pipe with valid bit.
//   DRN0: RD_LAT cycles, we=0, no new issue; skipped when RD_LAT=0. Then WR1, addr=DEPTH-1.
//   WR1: writes ~P(addr), addr DEPTH-1..0 desc. At 0 -> RD1, addr=DEPTH-1.
//   RD1: reads desc, expected ~P(addr). DRN1 same as DRN0. Then FIN.
//   FIN: one cycle: done=1, busy=0, pass=(err_cnt==0) registered; -> IDLE.
//  busy high from cycle after start through DRN1: exactly 4*DEPTH + 2*RD_LAT cycles.
//  Compare: when pipe output valid and mem_rdat != expected, err_cnt += 1 unless all-ones (saturate).
//  Address counter wraps at DEPTH-1, not 2^AW; non-power-of-2 DEPTH (e.g. 480) never issues addr >= DEPTH.
//  mem_we never asserted in RD*/DRN*/FIN/IDLE; mem_wdat = 0 when mem_we=0.
//  Reset mid-march: abort immediately to reset values, no done pulse; next start runs a full march.
//  start in same cycle as rst: rst wins.
//  NUM_BLOCKS=1: AW=4, same sequence over 16 words.
// CONFIGURATION
//  LUTRAM_BIST_FAILCAP_EN defined: adds outputs fail_addr[AW], fail_exp[DW], fail_got[DW], fail_vld.
//   These capture the first mismatch of a march (address, expected, read data). fail_vld is sticky.
//   All cleared on rst and on accepted start.
//  Not defined: those ports and capture registers absent; all other behaviour identical.
// TESTING
//  1. Defaults, ideal behavioural array, start pulse -> busy for 1920 cycles, done pulse, pass=1, err_cnt=0.
//  2. RD_LAT=1, array with registered read -> busy 1922 cycles, pass=1; mem_addr never >= 480.
//  3. Array bit 3 of word 0x17 stuck-at-0; SEED=0 -> P(0x17)=0x017 (bit3=0, ok), ~P=0x3E8 (bit3=1, fails) -> err_cnt=1, pass=0.
//     With FAILCAP: fail_addr=0x17, fail_exp=0x3E8, fail_got=0x3E0.
//  4. Array rdat forced 0: each read pass mismatches every word whose expected != 0 -> err_cnt = 959 (SEED=0; only P(0)=0 matches), pass=0.
//     ECW=8 -> err_cnt saturates at 8'hFF.
//  5. rst pulse at cycle 700 of march -> next cycle busy=0, mem_we=0, no done.
//     Restart -> full 1920-cycle march, pass=1.
//  6. start pulsed repeatedly while busy -> ignored; exactly one done per accepted start; mem_we=1 only in WR phases.

Source files
------------

// File: rtl/lutram_bist.sv
// March BIST driver/checker for the LUTRAM stress array: write P, read P, write ~P, read ~P.
// A march occupies 4*DEPTH + 2*RD_LAT busy cycles; compares land RD_LAT cycles after issue.
// No backpressure. Defining LUTRAM_BIST_FAILCAP_EN adds first-mismatch capture ports.
module lutram_bist #(
  parameter int              NUM_BLOCKS = 30,
  parameter int              DW         = 10,
  parameter int              RD_LAT     = 0,
  parameter logic [DW-1:0]   SEED       = 10'h2A5,
  parameter int              ECW        = 16,
  localparam int             DEPTH      = NUM_BLOCKS * 16,
  localparam int             AW         = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ECW-1:0]     err_cnt,
`ifdef LUTRAM_BIST_FAILCAP_EN
  output logic [AW-1:0]      fail_addr,
  output logic [DW-1:0]      fail_exp,
  output logic [DW-1:0]      fail_got,
  output logic               fail_vld,
`endif
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic [DW-1:0]      mem_wdat,
  input  logic [DW-1:0]      mem_rdat
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WR0, RD0, DRN0, WR1, RD1, DRN1, FIN} state_t;

  state_t     state;
  logic [1:0] drn_cnt;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return DW'(a) ^ SEED;
  endfunction

  // Compare pipe entry: {[addr,] expected, valid}, delayed to line up with mem_rdat.
`ifdef LUTRAM_BIST_FAILCAP_EN
  localparam int PW = 1 + DW + AW;
`else
  localparam int PW = 1 + DW;
`endif

  logic [PW-1:0] pipe_in, pipe_out;
  logic          rd_issue;
  logic [DW-1:0] exp_in;

  assign rd_issue = (state == RD0) || (state == RD1);
  assign exp_in   = (state == RD1) ? ~pat(mem_addr) : pat(mem_addr);

`ifdef LUTRAM_BIST_FAILCAP_EN
  assign pipe_in = {mem_addr, exp_in, rd_issue};
`else
  assign pipe_in = {exp_in, rd_issue};
`endif

  generate
    if (RD_LAT == 0) begin : g_nopipe
      assign pipe_out = pipe_in;
    end else begin : g_pipe
      logic [PW-1:0] stg [RD_LAT];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT; i++) stg[i] <= '0;
        end else begin
          stg[0] <= pipe_in;
          for (int i = 1; i < RD_LAT; i++) stg[i] <= stg[i-1];
        end
      end
      assign pipe_out = stg[RD_LAT-1];
    end
  endgenerate

  logic          p_vld;
  logic [DW-1:0] p_exp;
  logic          mismatch;
  logic [ECW-1:0] err_nxt;

  assign p_vld    = pipe_out[0];
  assign p_exp    = pipe_out[DW:1];
  assign mismatch = p_vld && (mem_rdat != p_exp);
  assign err_nxt  = (mismatch && (err_cnt != '1)) ? err_cnt + ECW'(1) : err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      drn_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_wdat <= '0;
`ifdef LUTRAM_BIST_FAILCAP_EN
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      fail_vld  <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      err_cnt <= err_nxt;
`ifdef LUTRAM_BIST_FAILCAP_EN
      if (mismatch && !fail_vld) begin
        fail_addr <= pipe_out[PW-1:DW+1];
        fail_exp  <= p_exp;
        fail_got  <= mem_rdat;
        fail_vld  <= 1'b1;
      end
`endif
      case (state)
        IDLE: if (start) begin
          state    <= WR0;
          busy     <= 1'b1;
          pass     <= 1'b0;
          err_cnt  <= '0;
          mem_addr <= '0;
          mem_we   <= 1'b1;
          mem_wdat <= pat('0);
`ifdef LUTRAM_BIST_FAILCAP_EN
          fail_addr <= '0;
          fail_exp  <= '0;
          fail_got  <= '0;
          fail_vld  <= 1'b0;
`endif
        end
        WR0: if (mem_addr == LAST) begin
          state    <= RD0;
          mem_addr <= '0;
          mem_we   <= 1'b0;
          mem_wdat <= '0;
        end else begin
          mem_addr <= mem_addr + AW'(1);
          mem_wdat <= pat(mem_addr + AW'(1));
        end
        RD0: if (mem_addr == LAST) begin
          if (RD_LAT == 0) begin
            state    <= WR1;
            mem_we   <= 1'b1;
            mem_wdat <= ~pat(LAST);
          end else begin
            state   <= DRN0;
            drn_cnt <= 2'(RD_LAT - 1);
          end
        end else begin
          mem_addr <= mem_addr + AW'(1);
        end
        DRN0: if (drn_cnt == 2'd0) begin
          state    <= WR1;
          mem_addr <= LAST;
          mem_we   <= 1'b1;
          mem_wdat <= ~pat(LAST);
        end else begin
          drn_cnt <= drn_cnt - 2'd1;
        end
        WR1: if (mem_addr == '0) begin
          state    <= RD1;
          mem_addr <= LAST;
          mem_we   <= 1'b0;
          mem_wdat <= '0;
        end else begin
          mem_addr <= mem_addr - AW'(1);
          mem_wdat <= ~pat(mem_addr - AW'(1));
        end
        RD1: if (mem_addr == '0) begin
          if (RD_LAT == 0) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            state   <= DRN1;
            drn_cnt <= 2'(RD_LAT - 1);
          end
        end else begin
          mem_addr <= mem_addr - AW'(1);
        end
        // The last compare lands on this edge, so pass looks at err_nxt.
        DRN1: if (drn_cnt == 2'd0) begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_nxt == '0);
        end else begin
          drn_cnt <= drn_cnt - 2'd1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lutram_bist.sv
// Directed bench for lutram_bist: four instances (default, RD_LAT=1/SEED=0 with fault
// injection, ECW=8 saturation, NUM_BLOCKS=1/RD_LAT=2) against behavioural array models.
module tb_lutram_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: defaults, async-read array
  logic start_a, busy_a, done_a, pass_a, we_a;
  logic [15:0] err_a;
  logic [8:0]  addr_a;
  logic [9:0]  wdat_a, rdat_a;
  logic [9:0]  mem_a [480];
  always @(posedge clk) if (we_a && addr_a < 9'd480) mem_a[addr_a] <= wdat_a;
  assign rdat_a = (addr_a < 9'd480) ? mem_a[addr_a] : 10'h000;

  // Instance B: RD_LAT=1, SEED=0, registered-read array with faults
  logic start_b, busy_b, done_b, pass_b, we_b, stuck_b, zero_b;
  logic [15:0] err_b;
  logic [8:0]  addr_b;
  logic [9:0]  wdat_b, rdat_b;
  logic [9:0]  mem_b [480];
  always @(posedge clk) begin
    if (we_b && addr_b < 9'd480) mem_b[addr_b] <= wdat_b;
    if (zero_b) rdat_b <= 10'h000;
    else if (addr_b < 9'd480)
      rdat_b <= mem_b[addr_b] & ~((stuck_b && addr_b == 9'h017) ? 10'h008 : 10'h000);
    else rdat_b <= 10'h000;
  end

  // Instance C: ECW=8, SEED=0, read data stuck at zero
  logic start_c, busy_c, done_c, pass_c, we_c;
  logic [7:0]  err_c;
  logic [8:0]  addr_c;
  logic [9:0]  wdat_c;
  logic [9:0]  rdat_c = 10'h000;

  // Instance D: NUM_BLOCKS=1, RD_LAT=2, two-stage read array
  logic start_d, busy_d, done_d, pass_d, we_d;
  logic [15:0] err_d;
  logic [3:0]  addr_d;
  logic [9:0]  wdat_d, rdat_d, rd1_d;
  logic [9:0]  mem_d [16];
  always @(posedge clk) begin
    if (we_d) mem_d[addr_d] <= wdat_d;
    rd1_d  <= mem_d[addr_d];
    rdat_d <= rd1_d;
  end

`ifdef LUTRAM_BIST_FAILCAP_EN
  logic [8:0] fa_a, fa_b, fa_c;
  logic [3:0] fa_d;
  logic [9:0] fe_a, fe_b, fe_c, fe_d, fg_a, fg_b, fg_c, fg_d;
  logic       fv_a, fv_b, fv_c, fv_d;
`endif

  lutram_bist u_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
`ifdef LUTRAM_BIST_FAILCAP_EN
    .fail_addr(fa_a), .fail_exp(fe_a), .fail_got(fg_a), .fail_vld(fv_a),
`endif
    .mem_addr(addr_a), .mem_we(we_a), .mem_wdat(wdat_a), .mem_rdat(rdat_a)
  );

  lutram_bist #(.RD_LAT(1), .SEED(10'h000)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
`ifdef LUTRAM_BIST_FAILCAP_EN
    .fail_addr(fa_b), .fail_exp(fe_b), .fail_got(fg_b), .fail_vld(fv_b),
`endif
    .mem_addr(addr_b), .mem_we(we_b), .mem_wdat(wdat_b), .mem_rdat(rdat_b)
  );

  lutram_bist #(.SEED(10'h000), .ECW(8)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
`ifdef LUTRAM_BIST_FAILCAP_EN
    .fail_addr(fa_c), .fail_exp(fe_c), .fail_got(fg_c), .fail_vld(fv_c),
`endif
    .mem_addr(addr_c), .mem_we(we_c), .mem_wdat(wdat_c), .mem_rdat(rdat_c)
  );

  lutram_bist #(.NUM_BLOCKS(1), .RD_LAT(2)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .done(done_d), .pass(pass_d), .err_cnt(err_d),
`ifdef LUTRAM_BIST_FAILCAP_EN
    .fail_addr(fa_d), .fail_exp(fe_d), .fail_got(fg_d), .fail_vld(fv_d),
`endif
    .mem_addr(addr_d), .mem_we(we_d), .mem_wdat(wdat_d), .mem_rdat(rdat_d)
  );

  // Free-running activity counters and protocol-violation counters per instance
  int bc_a = 0, dc_a = 0, wc_a = 0, bad_a = 0;
  int bc_b = 0, dc_b = 0, wc_b = 0, bad_b = 0;
  int bc_d = 0, dc_d = 0, wc_d = 0, bad_d = 0;
  always @(negedge clk) begin
    bc_a += int'(busy_a); dc_a += int'(done_a); wc_a += int'(we_a);
    if (addr_a >= 9'd480 || (!we_a && wdat_a != 10'h000) || (we_a && !busy_a)) bad_a++;
    bc_b += int'(busy_b); dc_b += int'(done_b); wc_b += int'(we_b);
    if (addr_b >= 9'd480 || (!we_b && wdat_b != 10'h000) || (we_b && !busy_b)) bad_b++;
    bc_d += int'(busy_d); dc_d += int'(done_d); wc_d += int'(we_d);
    if ((!we_d && wdat_d != 10'h000) || (we_d && !busy_d)) bad_d++;
  end

  task automatic set_start(input int w, input logic v);
    case (w)
      0: start_a = v;
      1: start_b = v;
      2: start_c = v;
      default: start_d = v;
    endcase
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0: return done_a;
      1: return done_b;
      2: return done_c;
      default: return done_d;
    endcase
  endfunction

  function automatic int bc_of(input int w);
    case (w)
      0: return bc_a;
      1: return bc_b;
      default: return bc_d;
    endcase
  endfunction

  function automatic int dc_of(input int w);
    case (w)
      0: return dc_a;
      1: return dc_b;
      default: return dc_d;
    endcase
  endfunction

  function automatic int wc_of(input int w);
    case (w)
      0: return wc_a;
      1: return wc_b;
      default: return wc_d;
    endcase
  endfunction

  task automatic run_march(input int w, input int hold, output int bcyc, output int dn, output int wn);
    int  b0, d0, w0;
    logic seen;
    b0 = bc_of(w); d0 = dc_of(w); w0 = wc_of(w);
    set_start(w, 1'b1);
    repeat (hold) tick();
    set_start(w, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      seen = done_of(w);
    end
    check("done_seen", 32'(seen), 32'd1);
    repeat (3) tick();
    bcyc = bc_of(w) - b0;
    dn   = dc_of(w) - d0;
    wn   = wc_of(w) - w0;
  endtask

  int bcyc, dn, wn, d_before;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    stuck_b = 1'b0; zero_b = 1'b0;
    repeat (3) tick();
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_pass",  32'(pass_a), 32'd0);
    check("rst_err",   32'(err_a),  32'd0);
    check("rst_addr",  32'(addr_a), 32'd0);
    check("rst_we",    32'(we_a),   32'd0);
    check("rst_wdat",  32'(wdat_a), 32'd0);
    rst = 1'b0;
    tick();

    // Default march on ideal array
    run_march(0, 1, bcyc, dn, wn);
    check("a_busy_cycles", 32'(bcyc), 32'd1920);
    check("a_done_count",  32'(dn),   32'd1);
    check("a_we_cycles",   32'(wn),   32'd960);
    check("a_pass",        32'(pass_a), 32'd1);
    check("a_err",         32'(err_a),  32'd0);
    repeat (10) tick();
    check("a_pass_held",   32'(pass_a), 32'd1);

    // start held high across the march start: only one march accepted
    run_march(0, 50, bcyc, dn, wn);
    check("a_rep_busy",  32'(bcyc), 32'd1920);
    check("a_rep_done",  32'(dn),   32'd1);
    check("a_rep_we",    32'(wn),   32'd960);
    repeat (20) tick();
    check("a_rep_idle",  32'(busy_a), 32'd0);

    // Reset mid-march aborts with no done; the next start runs a full march
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (700) tick();
    check("a_mid_busy", 32'(busy_a), 32'd1);
    d_before = dc_a;
    rst = 1'b1; tick();
    check("a_abort_busy", 32'(busy_a), 32'd0);
    check("a_abort_we",   32'(we_a),   32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("a_abort_no_done", 32'(dc_a - d_before), 32'd0);
    run_march(0, 1, bcyc, dn, wn);
    check("a_restart_busy", 32'(bcyc), 32'd1920);
    check("a_restart_pass", 32'(pass_a), 32'd1);

    // rst and start in the same cycle: rst wins
    rst = 1'b1; start_a = 1'b1; tick();
    rst = 1'b0; start_a = 1'b0; tick();
    check("a_rst_wins", 32'(busy_a), 32'd0);
    check("a_protocol", 32'(bad_a),  32'd0);

    // RD_LAT=1 clean, then stuck bit, then all-zero read data
    run_march(1, 1, bcyc, dn, wn);
    check("b_busy_cycles", 32'(bcyc), 32'd1922);
    check("b_pass",        32'(pass_b), 32'd1);
    check("b_err",         32'(err_b),  32'd0);
    stuck_b = 1'b1;
    run_march(1, 1, bcyc, dn, wn);
    check("b_stuck_err",  32'(err_b),  32'd1);
    check("b_stuck_pass", 32'(pass_b), 32'd0);
`ifdef LUTRAM_BIST_FAILCAP_EN
    check("b_fail_vld",  32'(fv_b), 32'd1);
    check("b_fail_addr", 32'(fa_b), 32'h017);
    check("b_fail_exp",  32'(fe_b), 32'h3E8);
    check("b_fail_got",  32'(fg_b), 32'h3E0);
`endif
    stuck_b = 1'b0; zero_b = 1'b1;
    run_march(1, 1, bcyc, dn, wn);
    check("b_zero_err",  32'(err_b),  32'd959);
    check("b_zero_pass", 32'(pass_b), 32'd0);
    zero_b = 1'b0;
    check("b_protocol",  32'(bad_b),  32'd0);

    // ECW=8 saturation
    run_march(2, 1, bcyc, dn, wn);
    check("c_sat_err",  32'(err_c),  32'h0FF);
    check("c_sat_pass", 32'(pass_c), 32'd0);

    // Single block, two-cycle read latency
    run_march(3, 1, bcyc, dn, wn);
    check("d_busy_cycles", 32'(bcyc), 32'd68);
    check("d_we_cycles",   32'(wn),   32'd32);
    check("d_pass",        32'(pass_d), 32'd1);
    check("d_err",         32'(err_d),  32'd0);
    check("d_protocol",    32'(bad_d),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
